seg7_sniffer: RTL and testbench
===============================

Name: seg7_sniffer

Overview:
- Receive-side counterpart of the team's 7-segment display path.
- Samples an external 7-segment bus, for example another tile's uo_out[6:0] wired into uio_in[6:0].
- Rejects glitches with a stability filter and decodes the pattern back to a BCD digit.
- Classifies each new digit as a count step up, a count step down, a skip, or an illegal pattern.
- Sits beside the counter/display logic in the top module as a self-check or loopback monitor.

Parameters:
- STABLE_CYCLES, 4: clk cycles the synchronised pattern must stay unchanged before acceptance. Legal range 1..255.
- CNT_W, 8: width of the stability counter. Must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_seg  in  7  segment bus, active-high; bit0=a through bit6=g. Asynchronous to clk.
- o_digit  out  4  last accepted legal digit, 0..9.
- o_valid  out  1  one-cycle pulse: new legal digit accepted.
- o_up  out  1  one-cycle pulse with o_valid: digit equals previous digit +1 mod 10.
- o_down  out  1  one-cycle pulse with o_valid: digit equals previous digit -1 mod 10.
- o_skip  out  1  one-cycle pulse with o_valid: a previous digit exists but is neither +1 nor -1.
- o_bad  out  1  one-cycle pulse: stable pattern accepted but not a legal digit.
- o_err_count  out  8  error counter; see Optional Feature.

Behaviour:
- Legal patterns: 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Every other value is illegal, including blank 7'h00.
- Synchroniser: 2-FF chain s1 -> s2. Register r_last holds the previous s2.
- Stability counter cnt:
  - Cleared when s2 != r_last.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Accept: occurs when s2 == r_last, cnt == STABLE_CYCLES-1, and s2 != r_acc (the last accepted pattern).
  - On accept, r_acc <= s2 and the registered outputs below update on the same edge.
  - At most one accept per stable period. A pattern equal to r_acc is never re-accepted.
- Accept of a legal pattern:
  - o_digit <= decoded value; o_valid <= 1.
  - If have_prev is set, exactly one of o_up / o_down / o_skip is asserted.
  - Wrap rules: 9->0 is up; 0->9 is down.
  - have_prev <= 1.
- Accept of an illegal pattern:
  - o_bad <= 1; o_digit is held; have_prev <= 0.
  - The next legal digit therefore gets o_valid with no direction pulse.
- Pulse rules:
  - All pulses deassert on the following edge.
  - o_valid and o_bad are mutually exclusive.
  - up/down/skip are asserted only together with o_valid.
- Latency: count the edge that first samples the new i_seg into s1 as edge 1. o_valid / o_bad is high after edge STABLE_CYCLES+3 (edge 7 at the default).
- Glitches: a pattern held for fewer than STABLE_CYCLES+1 cycles in s2 produces no output.
- Reset values: s1, s2, r_last = 0; r_acc = 7'h00; cnt = 0; have_prev = 0; o_digit = 0; all pulses = 0; o_err_count = 0.
- Reset mid-operation: async reset clears all state immediately. After release, a held blank pattern is never accepted. The first legal pattern needs a full stability period.

Optional Feature:
- Macro: SEG7_SNIFFER_ERRCNT_EN.
- Defined: o_err_count increments by 1 on each cycle where o_bad or o_skip is asserted. It saturates at 8'hFF and is cleared only by rst.
- Undefined: o_err_count is tied to 8'h00 and no counter flops are synthesised. The port list is unchanged.

Decomposition:
- Package seg7_pkg:
  - Constants SEG_0..SEG_9 and SEG_BLANK.
  - Function seg_decode: 7-bit pattern -> {legal, 4-bit digit}.
  - Localparam DIGIT_MAX = 9.
- Shared use: the display encoder uses the same constants, so encode and decode cannot diverge.
- Sub-module seg7_stable_filter: synchroniser, r_last, cnt, r_acc, and a one-cycle accept strobe with the accepted pattern. Parameterised by STABLE_CYCLES and CNT_W.
- Top level: decode, direction classification, pulses and error counter.

Test Plan:
- Reset, then hold i_seg=7'h3F for 12 cycles -> single o_valid at edge 7, o_digit=0, o_up/o_down/o_skip=0.
- 3F, 06, 5B, each held 8 cycles -> o_valid x3, digits 0,1,2; o_up on 1 and 2 only. Then 6F, 3F -> 9 then 0 with o_up on 0. Then 6F -> o_down.
- 06 stable, then 3F for 3 cycles, then back to 06 -> no o_valid, no o_bad, o_digit stays 1.
- Stable 5B, then illegal 7'h49 held 8 cycles -> one o_bad, o_digit stays 2. Then 66 -> o_valid, digit 4, no direction pulse.
- 5B then 6D (2->5) -> o_valid + o_skip. With SEG7_SNIFFER_ERRCNT_EN: 300 alternating bad/skip events -> o_err_count = 8'hFF; without the macro it stays 0.
- Hold 7F; assert rst at cnt=2 for 1 cycle -> all outputs 0 the same cycle. After release, 7F accepted STABLE_CYCLES+3 edges later with no direction pulse.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and helpers for the display encoder and the
// seg7_sniffer receive path, so encode and decode can never diverge.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int DIGIT_MAX = 9;

    typedef struct packed {
        logic       legal;
        logic [3:0] digit;
    } seg_dec_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_SKIP
    } dir_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    function automatic seg_dec_t seg_decode(input logic [6:0] pattern);
        seg_dec_t res;
        res.legal = 1'b1;
        res.digit = 4'd0;
        case (pattern)
            SEG_0:   res.digit = 4'd0;
            SEG_1:   res.digit = 4'd1;
            SEG_2:   res.digit = 4'd2;
            SEG_3:   res.digit = 4'd3;
            SEG_4:   res.digit = 4'd4;
            SEG_5:   res.digit = 4'd5;
            SEG_6:   res.digit = 4'd6;
            SEG_7:   res.digit = 4'd7;
            SEG_8:   res.digit = 4'd8;
            SEG_9:   res.digit = 4'd9;
            default: res.legal = 1'b0;
        endcase
        return res;
    endfunction

    // Direction of a digit change on a mod-10 counter: 9->0 is up, 0->9 is down.
    function automatic dir_e seg_classify(input logic [3:0] prev, input logic [3:0] cur);
        logic [3:0] next_val;
        logic [3:0] prev_val;
        dir_e       dir;
        next_val = (prev == 4'(DIGIT_MAX)) ? 4'd0 : prev + 4'd1;
        prev_val = (prev == 4'd0) ? 4'(DIGIT_MAX) : prev - 4'd1;
        if (cur == next_val) begin
            dir = DIR_UP;
        end else if (cur == prev_val) begin
            dir = DIR_DOWN;
        end else begin
            dir = DIR_SKIP;
        end
        return dir;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Synchronises an asynchronous 7-segment bus and emits a one-cycle accept
// strobe once a new pattern has been stable for STABLE_CYCLES clocks.
module seg7_stable_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_seg,
    output logic       o_accept,
    output logic [6:0] o_pattern
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_M1  = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       s1_q;
    logic [6:0]       s2_q;
    logic [6:0]       last_q;
    logic [6:0]       acc_q;
    logic [6:0]       acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    // Accept fires once per stable period; a pattern equal to the last
    // accepted one is never re-accepted, which also hides a held blank after reset.
    always_comb begin
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (s2_q != last_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != STABLE_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if ((cnt_q == STABLE_M1) && (s2_q != acc_q)) begin
                accept = 1'b1;
            end
        end
        acc_d = accept ? s2_q : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 7'h00;
            s2_q   <= 7'h00;
            last_q <= 7'h00;
            acc_q  <= SEG_BLANK;
            cnt_q  <= '0;
        end else begin
            s1_q   <= i_seg;
            s2_q   <= s1_q;
            last_q <= s2_q;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_accept  = accept;
    assign o_pattern = s2_q;

endmodule

// File: rtl/seg7_sniffer.sv
// Loopback monitor for a 7-segment bus: filters, decodes and classifies digits.
// Optional error counter enabled by defining SEG7_SNIFFER_ERRCNT_EN.
module seg7_sniffer
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_valid,
    output logic       o_up,
    output logic       o_down,
    output logic       o_skip,
    output logic       o_bad,
    output logic [7:0] o_err_count
);

    logic       accept;
    logic [6:0] pattern;
    seg_dec_t   dec;
    dir_e       dir;

    logic [3:0] digit_q, digit_d;
    logic       valid_q, valid_d;
    logic       up_q, up_d;
    logic       down_q, down_d;
    logic       skip_q, skip_d;
    logic       bad_q, bad_d;
    logic       have_prev_q, have_prev_d;

    seg7_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .i_seg     (i_seg),
        .o_accept  (accept),
        .o_pattern (pattern)
    );

    assign dec = seg_decode(pattern);
    assign dir = seg_classify(digit_q, dec.digit);

    // An illegal pattern breaks the direction history, so the next legal
    // digit is reported without an up/down/skip pulse.
    always_comb begin
        digit_d     = digit_q;
        valid_d     = 1'b0;
        up_d        = 1'b0;
        down_d      = 1'b0;
        skip_d      = 1'b0;
        bad_d       = 1'b0;
        have_prev_d = have_prev_q;
        if (accept) begin
            if (dec.legal) begin
                digit_d     = dec.digit;
                valid_d     = 1'b1;
                have_prev_d = 1'b1;
                if (have_prev_q) begin
                    up_d   = (dir == DIR_UP);
                    down_d = (dir == DIR_DOWN);
                    skip_d = (dir == DIR_SKIP);
                end
            end else begin
                bad_d       = 1'b1;
                have_prev_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q     <= 4'd0;
            valid_q     <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            skip_q      <= 1'b0;
            bad_q       <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            digit_q     <= digit_d;
            valid_q     <= valid_d;
            up_q        <= up_d;
            down_q      <= down_d;
            skip_q      <= skip_d;
            bad_q       <= bad_d;
            have_prev_q <= have_prev_d;
        end
    end

`ifdef SEG7_SNIFFER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((bad_q || skip_q) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_count = err_cnt_q;
`else
    assign o_err_count = 8'h00;
`endif

    assign o_digit = digit_q;
    assign o_valid = valid_q;
    assign o_up    = up_q;
    assign o_down  = down_q;
    assign o_skip  = skip_q;
    assign o_bad   = bad_q;

endmodule

// File: tb/tb_seg7_sniffer.sv
// Scoreboard bench for seg7_sniffer: stimulus pushes hand-computed events,
// a monitor pops and compares whenever o_valid or o_bad is presented.
module tb_seg7_sniffer;
    import seg7_pkg::*;

    localparam int STABLE = 4;
    localparam int LAT    = STABLE + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] i_seg;
    logic [3:0] o_digit;
    logic       o_valid;
    logic       o_up;
    logic       o_down;
    logic       o_skip;
    logic       o_bad;
    logic [7:0] o_err_count;

    typedef struct {
        int         cycle;
        logic       isBad;
        logic [3:0] digit;
        logic       up;
        logic       down;
        logic       skip;
    } expT;

    expT expQ[$];
    int  checks     = 0;
    int  errors     = 0;
    int  edgeCount  = 0;
    int  errEvents  = 0;
    logic [3:0] heldDigit;

    seg7_sniffer #(
        .STABLE_CYCLES (STABLE),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_seg       (i_seg),
        .o_digit     (o_digit),
        .o_valid     (o_valid),
        .o_up        (o_up),
        .o_down      (o_down),
        .o_skip      (o_skip),
        .o_bad       (o_bad),
        .o_err_count (o_err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, actual, expected, edgeCount);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] pattern, input int hold, input bit wantOut,
                                 input bit isBad, input logic [3:0] digit,
                                 input bit up, input bit down, input bit skip);
        expT e;
        i_seg = pattern;
        if (wantOut) begin
            e.cycle = edgeCount + LAT;
            e.isBad = isBad;
            e.digit = digit;
            e.up    = up;
            e.down  = down;
            e.skip  = skip;
            expQ.push_back(e);
            if (isBad || skip) errEvents++;
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        errEvents = 0;
    endtask

    // Monitor: pops one expected event per presented output
    always @(posedge clk) begin
        expT e;
        #1;
        if (!rst) begin
            checkOutput("pulseRules", 32'(((o_up | o_down | o_skip) & ~o_valid) | (o_valid & o_bad)), 32'd0);
            if (o_valid || o_bad) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedOutput: got valid=%0b bad=%0b digit=%0d at edge %0d, required no output",
                             o_valid, o_bad, o_digit, edgeCount);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("eventEdge", 32'(edgeCount), 32'(e.cycle));
                    checkOutput("eventKind", 32'({o_valid, o_bad}), 32'({~e.isBad, e.isBad}));
                    checkOutput("eventDigit", 32'(o_digit), 32'(e.digit));
                    checkOutput("eventDir", 32'({o_up, o_down, o_skip}), 32'({e.up, e.down, e.skip}));
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        i_seg = SEG_BLANK;
        repeat (3) @(negedge clk);
        checkOutput("resetDigit", 32'(o_digit), 32'd0);
        checkOutput("resetPulses", 32'({o_valid, o_up, o_down, o_skip, o_bad}), 32'd0);
        checkOutput("resetErrCount", 32'(o_err_count), 32'd0);
        rst = 1'b0;
        applyStimulus(SEG_BLANK, 12, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] single digit after reset");
        applyStimulus(SEG_0, 12, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        doReset();

        $display("[TB] counting sequence with wrap");
        applyStimulus(SEG_0, 8, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(SEG_1, 8, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(SEG_2, 8, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(SEG_9, 8, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);
        applyStimulus(SEG_0, 8, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(SEG_9, 8, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0);

        $display("[TB] glitch rejection");
        applyStimulus(SEG_1, 8, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
        applyStimulus(SEG_0, 3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(SEG_1, 8, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("glitchDigitHeld", 32'(o_digit), 32'd1);

        $display("[TB] illegal pattern");
        applyStimulus(SEG_2, 8, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(7'h49, 8, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("badDigitHeld", 32'(o_digit), 32'd2);
        applyStimulus(SEG_4, 8, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);

        $display("[TB] skips");
        applyStimulus(SEG_2, 8, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
        applyStimulus(SEG_5, 8, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1);
`ifdef SEG7_SNIFFER_ERRCNT_EN
        checkOutput("errCountPartial", 32'(o_err_count), 32'd5);
`else
        checkOutput("errCountPartial", 32'(o_err_count), 32'd0);
`endif

        $display("[TB] reset mid-operation");
        i_seg = SEG_8;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midResetDigit", 32'(o_digit), 32'd0);
        checkOutput("midResetPulses", 32'({o_valid, o_up, o_down, o_skip, o_bad}), 32'd0);
        checkOutput("midResetErrCount", 32'(o_err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        errEvents = 0;
        applyStimulus(SEG_8, 10, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0);

        $display("[TB] error counter stress");
        heldDigit = 4'd8;
        for (int i = 0; i < 150; i++) begin
            applyStimulus(7'h49, 8, 1'b1, 1'b1, heldDigit, 1'b0, 1'b0, 1'b0);
            applyStimulus(SEG_2, 8, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
            applyStimulus(SEG_5, 8, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1);
            heldDigit = 4'd5;
        end
        repeat (4) @(negedge clk);
`ifdef SEG7_SNIFFER_ERRCNT_EN
        checkOutput("errCountSaturated", 32'(o_err_count), (errEvents > 255) ? 32'd255 : 32'(errEvents));
`else
        checkOutput("errCountSaturated", 32'(o_err_count), 32'd0);
`endif

        repeat (10) @(negedge clk);
        checkOutput("pendingEvents", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
